weight_fifo_ctrl: RTL
=====================

WEIGHT_FIFO_CTRL -- requirements
Module: weight_fifo_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, meaning bits per weight element.
REQ-002 The block SHALL have parameter FIFO_WIDTH, default 16, meaning columns in the controlled weight FIFO.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 16, meaning rows (shift stages) in the controlled weight FIFO.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port cfg_start, input, 1 bit: one-cycle pulse that begins a load.
REQ-007 The block SHALL have port cfg_rows, input, $clog2(FIFO_DEPTH)+1 bits: number of data rows in the load, sampled with cfg_start.
REQ-008 The block SHALL have port in_valid, input, 1 bit: in_data holds a valid weight row.
REQ-009 The block SHALL have port in_ready, output, 1 bit: the controller accepts a row this cycle.
REQ-010 The block SHALL have port in_data, input, unpacked [0:FIFO_WIDTH-1] of DATA_WIDTH bits: one weight row.
REQ-011 The block SHALL have port drain_start, input, 1 bit: one-cycle pulse that begins a skewed drain.
REQ-012 The block SHALL have port fifo_en, output, FIFO_WIDTH bits: per-column shift enable to the weight FIFO.
REQ-013 The block SHALL have port fifo_w_in, output, unpacked [0:FIFO_WIDTH-1] of DATA_WIDTH bits: row driven into FIFO stage 0.
REQ-014 The block SHALL have port loaded, output, 1 bit: high while in state FULL.
REQ-015 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-016 The block SHALL have port done, output, 1 bit: one-cycle pulse on the last drain cycle.

Function
REQ-017 The block SHALL implement states IDLE, FILL, PAD, FULL and DRAIN, encoded as an explicit enumerated register.
REQ-018 In IDLE, cfg_start SHALL latch R = cfg_rows, using FIFO_DEPTH when cfg_rows is 0 or greater than FIFO_DEPTH, and move to FILL; drain_start SHALL be ignored.
REQ-019 In FILL, in_ready SHALL be 1, and every cycle with in_valid=1 SHALL drive fifo_en to all ones and fifo_w_in to in_data in the same cycle (zero latency) and increment the row counter.
REQ-020 In FILL, a cycle with in_valid=0 SHALL drive fifo_en to 0 and SHALL NOT count.
REQ-021 The cycle that accepts the R-th row SHALL transition to PAD if R < FIFO_DEPTH, else to FULL.
REQ-022 In PAD, in_ready SHALL be 0, fifo_en SHALL be all ones and fifo_w_in all zeros for exactly FIFO_DEPTH-R consecutive cycles, then the block SHALL enter FULL, so every load totals FIFO_DEPTH shifts.
REQ-023 In FULL, fifo_en SHALL be 0 and loaded SHALL be 1; drain_start SHALL move to DRAIN with drain counter k = 0.
REQ-024 DRAIN SHALL last FIFO_DEPTH+FIFO_WIDTH-1 cycles (k = 0 .. FIFO_DEPTH+FIFO_WIDTH-2); fifo_en[j] SHALL be 1 exactly when j <= k < j+FIFO_DEPTH; fifo_w_in SHALL be all zeros.
REQ-025 done SHALL pulse in the cycle k = FIFO_DEPTH+FIFO_WIDTH-2, and the next state SHALL be IDLE.
REQ-026 cfg_start outside IDLE and drain_start outside FULL SHALL be ignored; when both pulse in the same cycle, only the one legal in the current state SHALL take effect.
REQ-027 in_ready SHALL be 0 in every state except FILL; fifo_en SHALL be 0 in IDLE and FULL.
REQ-028 Counters SHALL be sized to hold FIFO_DEPTH+FIFO_WIDTH-1 without wrap-around, and SHALL clear on every state entry.

Reset
REQ-029 rstn low SHALL asynchronously force state IDLE, all counters and R to 0, and outputs in_ready=0, fifo_en=0, fifo_w_in=0, loaded=0, busy=0, done=0.
REQ-030 Reset asserted mid-FILL, PAD or DRAIN SHALL abort the operation with no further fifo_en pulses; after release the block SHALL wait in IDLE for cfg_start.

Verification (FIFO_DEPTH=4, FIFO_WIDTH=4)
REQ-031 Full load: cfg_start with cfg_rows=4, rows A,B,C,D with continuous in_valid -> four cycles of fifo_en=4'b1111, no PAD, loaded=1 on the next cycle; the downstream FIFO holds D,C,B,A from stage 0 to stage 3.
REQ-032 Partial load with gaps: cfg_rows=2, in_valid toggling 1,0,1 -> fifo_en=1111,0000,1111, then 2 PAD cycles with fifo_w_in=0, then loaded=1.
REQ-033 Skewed drain: drain_start in FULL -> 7 drain cycles with fifo_en = 0001,0011,0111,1111,1110,1100,1000 (bit 0 = column 0), done on the 7th cycle, then IDLE with busy=0.
REQ-034 Illegal commands: drain_start in IDLE and cfg_start during DRAIN -> no state change and no fifo_en activity caused by either command.
REQ-035 Reset mid-DRAIN at k=2 -> fifo_en=0 and busy=0 immediately while rstn is low, with no done pulse; cfg_rows=0 on the next load -> treated as 4.

Source files
------------

// File: rtl/weight_fifo_ctrl_if.sv
// Bundle between the weight-FIFO load/drain controller and its environment.
//   cfg_start/cfg_rows      : load command and row count (sampled together)
//   in_valid/in_ready/in_data : weight-row handshake into the controller
//   drain_start             : skewed-drain command
//   fifo_en/fifo_w_in       : per-column shift enables and stage-0 row to the weight FIFO
//   loaded/busy/done        : status
// Modport "slave" is the controller view; "master" is the driver/environment view.
interface weight_fifo_ctrl_if #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 16
);
  logic                        cfg_start;
  logic [$clog2(FIFO_DEPTH):0] cfg_rows;
  logic                        in_valid;
  logic                        in_ready;
  logic [DATA_WIDTH-1:0]       in_data   [0:FIFO_WIDTH-1];
  logic                        drain_start;
  logic [FIFO_WIDTH-1:0]       fifo_en;
  logic [DATA_WIDTH-1:0]       fifo_w_in [0:FIFO_WIDTH-1];
  logic                        loaded;
  logic                        busy;
  logic                        done;

  modport slave (
    input  cfg_start, cfg_rows, in_valid, in_data, drain_start,
    output in_ready, fifo_en, fifo_w_in, loaded, busy, done
  );

  modport master (
    output cfg_start, cfg_rows, in_valid, in_data, drain_start,
    input  in_ready, fifo_en, fifo_w_in, loaded, busy, done
  );
endinterface

// File: rtl/weight_fifo_ctrl.sv
// Load/drain controller for a FIFO_DEPTH x FIFO_WIDTH systolic weight FIFO.
// A load shifts R data rows in (R from cfg_rows, 0 or oversize meaning a full
// load), then zero rows so every load totals FIFO_DEPTH shifts. A drain then
// shifts each column j for FIFO_DEPTH cycles starting at cycle j, giving the
// diagonal skew the array expects.
// Ports:
//   clk  : rising-edge clock
//   rstn : asynchronous active-low reset
//   bus  : weight_fifo_ctrl_if.slave (commands, row handshake, FIFO drive, status)
module weight_fifo_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rstn,
  weight_fifo_ctrl_if.slave bus
);

  // One counter serves fill rows, pad cycles and drain index k; it must reach
  // FIFO_DEPTH+FIFO_WIDTH-2 without wrapping.
  localparam int CW = $clog2(FIFO_DEPTH + FIFO_WIDTH) + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FILL  = 3'd1;
  localparam logic [2:0] S_PAD   = 3'd2;
  localparam logic [2:0] S_FULL  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST_K_C = CW'(FIFO_DEPTH + FIFO_WIDTH - 2);
  localparam logic [CW-1:0] ONE_C    = CW'(1);

  logic [2:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [CW-1:0]         rows_q, rows_d;
  logic [CW-1:0]         cfg_ext_s;
  logic                  in_ready_s;
  logic [FIFO_WIDTH-1:0] fifo_en_s;
  logic [DATA_WIDTH-1:0] w_in_s [0:FIFO_WIDTH-1];

  assign cfg_ext_s = CW'(bus.cfg_rows);

  // Next-state, counter and zero-latency FIFO drive decode.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rows_d     = rows_q;
    in_ready_s = 1'b0;
    fifo_en_s  = '0;
    for (int j = 0; j < FIFO_WIDTH; j++) begin
      w_in_s[j] = '0;
    end
    case (state_q)
      S_IDLE: begin
        if (bus.cfg_start) begin
          state_d = S_FILL;
          cnt_d   = '0;
          // Zero or oversize row count means a full-depth load.
          if ((cfg_ext_s == '0) || (cfg_ext_s > DEPTH_C)) begin
            rows_d = DEPTH_C;
          end else begin
            rows_d = cfg_ext_s;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FILL: begin
        in_ready_s = 1'b1;
        if (bus.in_valid) begin
          fifo_en_s = '1;
          for (int j = 0; j < FIFO_WIDTH; j++) begin
            w_in_s[j] = bus.in_data[j];
          end
          if ((cnt_q + ONE_C) == rows_q) begin
            cnt_d   = '0;
            state_d = (rows_q < DEPTH_C) ? S_PAD : S_FULL;
          end else begin
            cnt_d = cnt_q + ONE_C;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_PAD: begin
        // Zero rows fill the stages the short load left behind.
        fifo_en_s = '1;
        if ((cnt_q + ONE_C) == (DEPTH_C - rows_q)) begin
          cnt_d   = '0;
          state_d = S_FULL;
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      end
      S_FULL: begin
        if (bus.drain_start) begin
          cnt_d   = '0;
          state_d = S_DRAIN;
        end else begin
          state_d = S_FULL;
        end
      end
      S_DRAIN: begin
        // Column j shifts during k = j .. j+FIFO_DEPTH-1.
        for (int j = 0; j < FIFO_WIDTH; j++) begin
          fifo_en_s[j] = (cnt_q >= CW'(j)) && (cnt_q < CW'(j + FIFO_DEPTH));
        end
        if (cnt_q == LAST_K_C) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        rows_d  = '0;
      end
    endcase
  end

  // State, counter and latched row-count registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rows_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rows_q  <= rows_d;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.fifo_en   = fifo_en_s;
  assign bus.fifo_w_in = w_in_s;
  assign bus.loaded    = (state_q == S_FULL);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_DRAIN) && (cnt_q == LAST_K_C);

endmodule
